dbus_responder: RTL and testbench

DBUS_RESPONDER -- requirements
Module: dbus_responder

---
 rtl/dbus_pkg.sv | 10 +
 rtl/dbus_ram.sv | 18 +
 rtl/dbus_responder.sv | 95 +++++++++
 tb/tb_dbus_responder.sv | 134 +++++++++++++
 4 files changed

// File: rtl/dbus_pkg.sv
// dbus_pkg: shared FSM states, I/O map defaults and byte-lane merge helper
package dbus_pkg;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  localparam logic [31:0] IO_BASE_DEF = 32'h8000_0000;
  localparam logic [31:0] GPIO_OFF = 32'h0;
  localparam logic [31:0] CYCLE_OFF = 32'h4;
  function automatic logic [31:0] merge_be(input logic [31:0] o, input logic [31:0] n, input logic [3:0] be);
    for (int i = 0; i < 4; i++) merge_be[8*i+:8] = be[i] ? n[8*i+:8] : o[8*i+:8];
  endfunction
endpackage

// File: rtl/dbus_ram.sv
// dbus_ram: single-port RAM, per-byte write enable, registered read
// clk clock; we write strobe; be byte lanes; addr word address; wdata/rdata data
module dbus_ram #(
  parameter int AW = 10
) (
  input  logic          clk,
  input  logic          we,
  input  logic [3:0]    be,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);
  logic [31:0] mem [2**AW];
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) if (we && be[i]) mem[addr][8*i+:8] <= wdata[8*i+:8];
    rdata <= mem[addr];
  end
endmodule

// File: rtl/dbus_responder.sv
// dbus_responder: CPU data-bus slave with RAM, GPIO and free-running CYCLE counter
// CLK clock; RES sync active-high reset; RD/WR requests; BE lanes; DADDR byte address;
// DATAO write data; DATAI read data; HLT stall; GPIO_OUT output register.
// DBUS_WAITSTATE_EN adds WAIT_STATES stall cycles and buffers writes until RESP.
module dbus_responder
  import dbus_pkg::*;
#(
  parameter int          MEM_WORDS   = 1024,
  parameter int          WAIT_STATES = 2,
  parameter logic [31:0] IO_BASE     = IO_BASE_DEF
) (
  input  logic        CLK,
  input  logic        RES,
  input  logic        RD,
  input  logic        WR,
  input  logic [3:0]  BE,
  input  logic [31:0] DADDR,
  input  logic [31:0] DATAO,
  output logic [31:0] DATAI,
  output logic        HLT,
  output logic [31:0] GPIO_OUT
);
  localparam int AW = $clog2(MEM_WORDS);
  state_t state;
  logic [31:0] addr_q, a, off, wd, cyc, io_rd, ram_q, datai_q;
  logic [3:0] bs;
  logic wr_q, req, commit, io;
  assign req = RD | WR;
  // Live address while idle so the RAM read launches in the request cycle
  assign a = state == IDLE ? DADDR : addr_q;
  assign io = a[31];
  assign off = (a - IO_BASE) & 32'hFFFF_FFFC;
`ifdef DBUS_WAITSTATE_EN
  localparam logic [3:0] WS1 = 4'(WAIT_STATES > 0 ? WAIT_STATES - 1 : 0);
  logic [3:0] cnt, be_q;
  logic [31:0] data_q;
  assign HLT = (state == IDLE || state == WAIT) && req;
  assign commit = state == RESP && wr_q && !RES;
  assign wd = data_q;
  assign bs = be_q;
`else
  // Writes post in the request cycle; only reads stall
  assign HLT = state == IDLE && RD && !WR;
  assign commit = state == IDLE && WR && !RES;
  assign wd = DATAO;
  assign bs = BE;
`endif
  assign DATAI = state == RESP ? (wr_q ? 32'h0 : io ? io_rd : ram_q) : datai_q;
  dbus_ram #(.AW(AW)) u_ram (
    .clk(CLK), .we(commit && !io), .be(bs), .addr(a[AW+1:2]), .wdata(wd), .rdata(ram_q)
  );
  always_ff @(posedge CLK) begin
    if (RES) begin
      state <= IDLE;
      datai_q <= 32'h0;
      GPIO_OUT <= 32'h0;
      cyc <= 32'h0;
      io_rd <= 32'h0;
      addr_q <= 32'h0;
      wr_q <= 1'b0;
`ifdef DBUS_WAITSTATE_EN
      cnt <= 4'h0;
      be_q <= 4'h0;
      data_q <= 32'h0;
`endif
    end else begin
      cyc <= cyc + 32'h1;
      io_rd <= !io ? 32'h0 : off == GPIO_OFF ? GPIO_OUT : off == CYCLE_OFF ? cyc : 32'h0;
      if (commit && io && off == GPIO_OFF) GPIO_OUT <= merge_be(GPIO_OUT, wd, bs);
      if (state == RESP) datai_q <= DATAI;
      case (state)
        IDLE: if (HLT) begin
          addr_q <= DADDR;
          wr_q <= WR;
`ifdef DBUS_WAITSTATE_EN
          be_q <= BE;
          data_q <= DATAO;
          cnt <= WS1;
          state <= WAIT_STATES > 0 ? WAIT : RESP;
`else
          state <= RESP;
`endif
        end
`ifdef DBUS_WAITSTATE_EN
        WAIT: begin
          if (!req) state <= IDLE;
          else if (cnt == 4'h0) state <= RESP;
          else cnt <= cnt - 4'h1;
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dbus_responder.sv
// tb_dbus_responder: randomized bus accesses checked against a word-array reference model
module tb_dbus_responder;
  localparam int WS = 2;
  localparam int MW = 1024;
`ifdef DBUS_WAITSTATE_EN
  localparam bit WSE = 1'b1;
`else
  localparam bit WSE = 1'b0;
`endif
  localparam int RD_PER = WSE ? 2 + WS : 2;
  localparam int WR_PER = WSE ? 2 + WS : 1;
  logic CLK = 0, RES = 1, RD = 0, WR = 0, HLT;
  logic [3:0] BE = 0;
  logic [31:0] DADDR = 0, DATAO = 0, DATAI, GPIO_OUT;
  logic [31:0] m [MW];
  logic [31:0] gpio = 0;
  int n_tests = 0, n_fail = 0;
  dbus_responder #(.MEM_WORDS(MW), .WAIT_STATES(WS)) dut (
    .CLK(CLK), .RES(RES), .RD(RD), .WR(WR), .BE(BE), .DADDR(DADDR),
    .DATAO(DATAO), .DATAI(DATAI), .HLT(HLT), .GPIO_OUT(GPIO_OUT)
  );
  always #5 CLK = ~CLK;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic logic [31:0] lanes(input logic [31:0] o, input logic [31:0] n, input logic [3:0] be);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[8*i+:8] = be[i] ? n[8*i+:8] : o[8*i+:8];
    return r;
  endfunction
  task automatic access(input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] be, output logic [31:0] q, output int h);
    RD = rd; WR = wr; DADDR = a; DATAO = d; BE = be; h = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge CLK);
      if (!HLT) break;
      h++;
      @(posedge CLK); #1;
      DADDR = $urandom; DATAO = $urandom; BE = 4'($urandom);
    end
    if (h >= 40) chk("hlt timeout", {31'h0, HLT}, 32'h0);
    q = DATAI;
    @(posedge CLK); #1;
    RD = 0; WR = 0;
  endtask
  task automatic do_acc(input string tag, input bit rd, input bit wr, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] be, output logic [31:0] q);
    int h, idx;
    logic [31:0] off;
    access(rd, wr, a, d, be, q, h);
    idx = int'((a >> 2) % MW);
    off = {a[31:2], 2'b00} - 32'h8000_0000;
    chk({tag, " hlt"}, 32'(h), 32'((WSE || !wr) ? (WSE ? 1 + WS : 1) : 0));
    if (wr) begin
`ifdef DBUS_WAITSTATE_EN
      chk({tag, " wdata0"}, q, 32'h0);
`endif
      if (!a[31]) m[idx] = lanes(m[idx], d, be);
      else if (off == 0) gpio = lanes(gpio, d, be);
    end else if (!(a[31] && off == 4)) chk({tag, " data"}, q, a[31] ? (off == 0 ? gpio : 32'h0) : m[idx]);
    chk({tag, " gpio"}, GPIO_OUT, gpio);
  endtask
  initial begin
    logic [31:0] q, c1, c2, c3, a, pd;
    int k, r;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    chk("rst hlt", {31'h0, HLT}, 32'h0);
    chk("rst datai", DATAI, 32'h0);
    chk("rst gpio", GPIO_OUT, 32'h0);
    @(posedge CLK); #1;
    RES = 0;
    do_acc("wr beef", 0, 1, 32'h10, 32'hDEAD_BEEF, 4'hF, q);
    do_acc("rd beef", 1, 0, 32'h10, 0, 4'h0, q);
    @(negedge CLK);
    chk("datai hold", DATAI, 32'hDEAD_BEEF);
    @(posedge CLK); #1;
    do_acc("wr ones", 0, 1, 32'h14, 32'hFFFF_FFFF, 4'hF, q);
    do_acc("wr lanes", 0, 1, 32'h14, 32'h1122_3344, 4'b0101, q);
    do_acc("rd lanes", 1, 0, 32'h14, 0, 4'hF, q);
    chk("lanes val", q, 32'hFF22_FF44);
    do_acc("wr be0", 0, 1, 32'h14, 32'h0, 4'h0, q);
    do_acc("rd be0", 1, 0, 32'h14, 0, 4'h0, q);
    do_acc("wr gpio", 0, 1, 32'h8000_0000, 32'hA5, 4'hF, q);
    chk("gpio a5", GPIO_OUT, 32'hA5);
    do_acc("rd cyc1", 1, 0, 32'h8000_0004, 0, 4'hF, c1);
    do_acc("rd cyc2", 1, 0, 32'h8000_0004, 0, 4'hF, c2);
    chk("cyc rd period", c2 - c1, 32'(RD_PER));
    do_acc("wr cyc", 0, 1, 32'h8000_0004, 32'h0, 4'hF, q);
    do_acc("rd cyc3", 1, 0, 32'h8000_0004, 0, 4'hF, c3);
    chk("cyc unaffected", c3 - c2, 32'(RD_PER + WR_PER));
    do_acc("wr alias", 0, 1, 32'h20, 32'h5, 4'hF, q);
    do_acc("rd alias", 1, 0, 32'h1020, 0, 4'h0, q);
    do_acc("wr 40", 0, 1, 32'h40, 32'h0BAD_F00D, 4'hF, q);
`ifdef DBUS_WAITSTATE_EN
    pd = DATAI;
    RD = 1; DADDR = 32'h10;
    @(negedge CLK);
    chk("abort hlt idle", {31'h0, HLT}, 32'h1);
    @(posedge CLK); #1;
    RD = 0;
    @(negedge CLK);
    chk("abort hlt wait", {31'h0, HLT}, 32'h0);
    @(posedge CLK); #1;
    @(negedge CLK);
    chk("abort hlt next", {31'h0, HLT}, 32'h0);
    chk("abort datai", DATAI, pd);
    @(posedge CLK); #1;
    WR = 1; DADDR = 32'h40; DATAO = 32'h1234_5678; BE = 4'hF;
    @(posedge CLK); #1;
    RES = 1; WR = 0;
    @(posedge CLK); #1;
    RES = 0;
    gpio = 0;
    chk("rst gpio mid", GPIO_OUT, 32'h0);
`endif
    do_acc("rd 40", 1, 0, 32'h40, 0, 4'h0, q);
    for (int i = 0; i < 16; i++) do_acc("init", 0, 1, 32'(i * 4), $urandom, 4'hF, q);
    for (int i = 0; i < 200; i++) begin
      k = $urandom_range(0, 9);
      r = $urandom_range(0, 2);
      if (k < 7) a = ($urandom & 32'h7FFF_F000) | 32'($urandom_range(0, 15) << 2) | 32'($urandom_range(0, 3));
      else if (k < 9) a = 32'h8000_0000 | 32'($urandom_range(0, 3));
      else a = 32'h8000_0000 + 32'(4 * $urandom_range(2, 100));
      do_acc(r == 0 ? "rnd rd" : r == 1 ? "rnd wr" : "rnd rdwr", r != 1, r != 0, a, $urandom, 4'($urandom), q);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
